// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

    // Iteration counter must hold WIDTH-1; keep at least one bit for tiny widths.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// 2*WIDTH accumulator: operand magnitude capture, one shift-add or
// restoring-subtract step per strobe, and sign correction of the result.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  op_t              op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd_b;
    op_t                op_r;
    logic               neg_main;
    logic               neg_rem;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quot_neg;
    logic [WIDTH-1:0]   rem_neg;

    // Operand magnitudes and per-step arithmetic.
    always_comb begin
        a_neg    = is_signed & src_a[WIDTH-1];
        b_neg    = is_signed & src_b[WIDTH-1];
        a_mag    = a_neg ? -src_a : src_a;
        b_mag    = b_neg ? -src_b : src_b;
        // Multiply: add multiplicand into the upper half, carry kept for the shift.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd_b};
        // Divide: partial remainder shifted left by one, trial-subtract divisor.
        div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_b};
    end

    // Accumulator and latched operation context.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            opnd_b   <= '0;
            op_r     <= OP_MUL;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (load) begin
            acc      <= {{WIDTH{1'b0}}, a_mag};
            opnd_b   <= b_mag;
            op_r     <= op;
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
        end else if (step) begin
            if (op_r == OP_MUL) begin
                if (acc[0]) begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                end else begin
                    acc <= {1'b0, acc[2*WIDTH-1:1]};
                end
            end else begin
                if (!div_diff[WIDTH]) begin
                    acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                end else begin
                    acc <= {acc[2*WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    // Sign-corrected result while fixing; raw accumulator halves otherwise.
    always_comb begin
        prod_neg = -acc;
        quot_neg = -acc[WIDTH-1:0];
        rem_neg  = -acc[2*WIDTH-1:WIDTH];
        res_hi   = acc[2*WIDTH-1:WIDTH];
        res_lo   = acc[WIDTH-1:0];
        if (fix) begin
            if (op_r == OP_MUL) begin
                if (neg_main) begin
                    res_hi = prod_neg[2*WIDTH-1:WIDTH];
                    res_lo = prod_neg[WIDTH-1:0];
                end
            end else begin
                if (neg_main) res_lo = quot_neg;
                if (neg_rem)  res_hi = rem_neg;
            end
        end
    end

endmodule

// File: rtl/muldiv_controller.sv
// Multiply/divide sequencer: owns HI/LO, runs one op in the background and
// raises a Decode stall while an op is in flight.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | accepts mult/div starts and mthi/mtlo writes
//   CALC  | one multiply/divide iteration per cycle, counter runs down
//   FIX   | sign correction applied, HI/LO written, back to IDLE
module muldiv_controller
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             MultE,
    input  logic             DivE,
    input  logic             SignedE,
    input  logic             MthiE,
    input  logic             MtloE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             HiLoUseD,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             StallHiLoD
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    op_t              op_r;
    op_t              op_sel;
    logic             div_zero;
    logic [WIDTH-1:0] src_a_r;

    logic             load;
    logic             step;
    logic             fix;
    logic             wr_hilo;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .fix       (fix),
        .op        (op_sel),
        .is_signed (SignedE),
        .src_a     (SrcAE),
        .src_b     (SrcBE),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    // Next-state, counter and datapath strobes.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        step       = 1'b0;
        fix        = 1'b0;
        wr_hilo    = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        op_sel     = MultE ? OP_MUL : OP_DIV;
        case (state)
            IDLE: begin
                if (MultE || DivE) begin
                    // A start swallows any mthi/mtlo in the same cycle.
                    load       = 1'b1;
                    cnt_next   = CNT_W'(WIDTH - 1);
                    state_next = CALC;
                end else begin
                    wr_hi = MthiE;
                    wr_lo = MtloE;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt == '0) begin
                    state_next = FIX;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            FIX: begin
                fix        = 1'b1;
                wr_hilo    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Divide by zero bypasses sign correction: all-ones quotient, raw dividend.
    always_comb begin
        fix_hi = res_hi;
        fix_lo = res_lo;
        if (op_r == OP_DIV && div_zero) begin
            fix_hi = src_a_r;
            fix_lo = '1;
        end
    end

    // FSM state, iteration counter and op context captured at start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_r     <= OP_MUL;
            div_zero <= 1'b0;
            src_a_r  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (load) begin
                op_r     <= op_sel;
                div_zero <= (SrcBE == '0);
                src_a_r  <= SrcAE;
            end
        end
    end

    // Architectural HI/LO: written only by FIX or by mthi/mtlo in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            HI <= '0;
            LO <= '0;
        end else if (wr_hilo) begin
            HI <= fix_hi;
            LO <= fix_lo;
        end else begin
            if (wr_hi) HI <= SrcAE;
            if (wr_lo) LO <= SrcAE;
        end
    end

    // Busy covers the start cycle combinationally so Decode stalls immediately.
    always_comb begin
        Busy       = (state != IDLE) || MultE || DivE;
        StallHiLoD = HiLoUseD && Busy;
    end

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed bench: stimulus pushes expected HI/LO into a scoreboard; a monitor
// pops and compares whenever Busy falls (the result has been written).
module tb_muldiv_controller;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         MultE, DivE, SignedE, MthiE, MtloE, HiLoUseD;
    logic [W-1:0] SrcAE, SrcBE;
    logic [W-1:0] HI, LO;
    logic         Busy, StallHiLoD;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } exp_t;

    exp_t sb_q[$];
    bit   discard   = 1'b0;
    logic prev_busy = 1'b0;

    muldiv_controller #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .MultE      (MultE),
        .DivE       (DivE),
        .SignedE    (SignedE),
        .MthiE      (MthiE),
        .MtloE      (MtloE),
        .SrcAE      (SrcAE),
        .SrcBE      (SrcBE),
        .HiLoUseD   (HiLoUseD),
        .HI         (HI),
        .LO         (LO),
        .Busy       (Busy),
        .StallHiLoD (StallHiLoD)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: a falling Busy marks a freshly written result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (prev_busy && !Busy) begin
                if (discard) begin
                    discard = 1'b0;
                end else if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual HI=%h LO=%h required none", HI, LO);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_HI"}, HI, e.hi);
                    check({e.name, "_LO"}, LO, e.lo);
                end
            end
            prev_busy = Busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Issue one op, push its expected result, and check Busy/stall durations.
    task automatic do_op(input string name, input bit m, input bit d, input bit s,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] hi_e, input logic [W-1:0] lo_e,
                         input bit use_hilo);
        int   busy_n;
        int   stall_n;
        exp_t e;
        @(posedge clk); #1;
        MultE = m; DivE = d; SignedE = s; SrcAE = a; SrcBE = b; HiLoUseD = use_hilo;
        e.hi = hi_e; e.lo = lo_e; e.name = name;
        sb_q.push_back(e);
        busy_n  = 0;
        stall_n = 0;
        @(negedge clk);
        busy_n  += int'(Busy);
        stall_n += int'(StallHiLoD);
        @(posedge clk); #1;
        MultE = 1'b0; DivE = 1'b0;
        // Operands change after start; the unit must work from its latched copy.
        SrcAE = 32'hDEAD_BEEF; SrcBE = 32'h0BAD_F00D;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!Busy) break;
            busy_n  += 1;
            stall_n += int'(StallHiLoD);
        end
        check({name, "_busy_cycles"}, W'(busy_n), 32'd34);
        check({name, "_stall_cycles"}, W'(stall_n), use_hilo ? 32'd34 : 32'd0);
        if (use_hilo) check({name, "_stall_released"}, {31'd0, StallHiLoD}, 32'd0);
        HiLoUseD = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        MultE = 1'b0; DivE = 1'b0; SignedE = 1'b0; MthiE = 1'b0; MtloE = 1'b0;
        SrcAE = '0; SrcBE = '0; HiLoUseD = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",  {31'd0, Busy}, 32'd0);
        check("reset_stall", {31'd0, StallHiLoD}, 32'd0);
        check("reset_HI", HI, 32'd0);
        check("reset_LO", LO, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; HiLoUseD = 1'b0;

        //     name          mult  div  sgn  A              B              HI             LO             use
        do_op("multu_max",   1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
        do_op("mult_neg",    1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        do_op("div_neg",     1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        do_op("divu_zero",   1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
        do_op("div_ovf",     1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        do_op("div_negb",    1'b0, 1'b1, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        do_op("divu_100_7",  1'b0, 1'b1, 1'b0, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0);
        do_op("mult_negneg", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_0018, 1'b0);
        do_op("mul_wins",    1'b1, 1'b1, 1'b0, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A, 1'b0);
        do_op("div_zero_s",  1'b0, 1'b1, 1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);

        // mthi / mtlo in IDLE: visible the cycle after.
        @(posedge clk); #1;
        MthiE = 1'b1; SrcAE = 32'hA5A5_A5A5;
        @(negedge clk);
        check("mthi_not_yet", HI, 32'hFFFF_FFFB);
        @(posedge clk); #1;
        MthiE = 1'b0; MtloE = 1'b1; SrcAE = 32'h5A5A_1234;
        @(negedge clk);
        check("mthi_HI", HI, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        MtloE = 1'b0; SrcAE = 32'h0;
        @(negedge clk);
        check("mtlo_LO", LO, 32'h5A5A_1234);
        check("mtlo_keeps_HI", HI, 32'hA5A5_A5A5);

        // Reset during CALC cycle 10 of a divide discards it.
        @(posedge clk); #1;
        DivE = 1'b1; SignedE = 1'b1; SrcAE = 32'd100; SrcBE = 32'd3; discard = 1'b1;
        @(posedge clk); #1;
        DivE = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1; HiLoUseD = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy",  {31'd0, Busy}, 32'd0);
        check("abort_stall", {31'd0, StallHiLoD}, 32'd0);
        check("abort_HI", HI, 32'd0);
        check("abort_LO", LO, 32'd0);
        HiLoUseD = 1'b0;

        do_op("multu_6x7",   1'b1, 1'b0, 1'b0, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", W'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
